// File: rtl/multicycle_sequencer_if.sv
// Memory port shared between instruction fetch and load/store.
//   mem_req   : access request, held until the cycle mem_ready=1 (inclusive)
//   mem_we    : 1 = store, 0 = read
//   addr_sel  : address mux select, 0 = PC, 1 = ALU result
//   mem_ready : memory acknowledge, only meaningful while mem_req=1
// Modports: master = sequencer side, slave = memory side.
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: steps the datapath through
// FETCH/DECODE/EXEC/MEM/WB, gates the single-cycle decoder outputs into
// per-phase strobes, shares one memory port between fetch and load/store
// and retires one instruction per pass.
//
// Parameters:
//   MEM_TIMEOUT : cycles in FETCH/MEM without mem_ready before ERR (0 = none)
//   TMO_W       : timeout counter width, 2**TMO_W > MEM_TIMEOUT
// Optional feature macro: PERF_CNT_EN (retired-instruction counter).
//
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start             : IDLE -> FETCH request, ignored when busy
//   halt_req          : sampled at retire, return to IDLE instead of FETCH
//   dec_mem_to_reg    : decoder load
//   dec_mem_write     : decoder store
//   dec_branch        : decoder branch
//   dec_reg_write     : decoder register writeback
//   branch_taken      : branch condition, valid in EXEC
//   mem               : memory port (mem_req/mem_we/addr_sel out, mem_ready in)
//   ir_we, pc_we      : instruction register load / PC update
//   pc_src_branch     : 1 = branch target, 0 = PC+4 (valid with pc_we)
//   reg_we            : register file write
//   retire            : one-cycle pulse in the last cycle of an instruction
//   busy, err         : state not IDLE/ERR; sticky memory timeout flag
//   state_o           : IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERR=6
//   instr_count       : retired count (PERF_CNT_EN), else 0
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          halt_req,
    input  logic                          dec_mem_to_reg,
    input  logic                          dec_mem_write,
    input  logic                          dec_branch,
    input  logic                          dec_reg_write,
    input  logic                          branch_taken,
    multicycle_sequencer_if.master        mem,
    output logic                          ir_we,
    output logic                          pc_we,
    output logic                          pc_src_branch,
    output logic                          reg_we,
    output logic                          retire,
    output logic                          busy,
    output logic                          err,
    output logic [2:0]                    state_o,
    output logic [31:0]                   instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             ld_q, ld_d;
    logic             st_q, st_d;
    logic             br_q, br_d;
    logic             rw_q, rw_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             addr_sel_q, addr_sel_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             tmo_hit;
`ifdef PERF_CNT_EN
    logic [31:0]      cnt_q, cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        ld_d          = ld_q;
        st_d          = st_q;
        br_d          = br_q;
        rw_d          = rw_q;
        tmo_d         = '0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src_branch = 1'b0;
        reg_we        = 1'b0;
        retire        = 1'b0;
        tmo_hit       = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                ld_d    = dec_mem_to_reg;
                st_d    = dec_mem_write;
                br_d    = dec_branch;
                rw_d    = dec_reg_write;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Priority branch > memory > writeback; nothing latched is a NOP.
                if (br_q) begin
                    pc_we         = branch_taken;
                    pc_src_branch = 1'b1;
                    retire        = 1'b1;
                end else if (st_q || ld_q) begin
                    state_d = S_MEM;
                end else if (rw_q) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (mem.mem_ready) begin
                    // Store wins when both load and store were latched.
                    if (st_q) retire  = 1'b1;
                    else      state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire) state_d = halt_req ? S_IDLE : S_FETCH;

        // Port outputs are registered from the next state so they are
        // glitch-free and stay stable across wait cycles.
        mem_req_d  = (state_d == S_FETCH) || (state_d == S_MEM);
        addr_sel_d = (state_d == S_MEM);
        mem_we_d   = (state_d == S_MEM) && st_d;
        busy_d     = (state_d != S_IDLE) && (state_d != S_ERR);
        err_d      = err_q || (state_d == S_ERR);
`ifdef PERF_CNT_EN
        cnt_d      = cnt_q + {31'd0, retire};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            br_q       <= 1'b0;
            rw_q       <= 1'b0;
            tmo_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PERF_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ld_q       <= ld_d;
            st_q       <= st_d;
            br_q       <= br_d;
            rw_q       <= rw_d;
            tmo_q      <= tmo_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_sel_q <= addr_sel_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef PERF_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.addr_sel = addr_sel_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign state_o      = state_q;
`ifdef PERF_CNT_EN
    assign instr_count  = cnt_q;
`else
    assign instr_count  = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer, plus directed
// timeout, halt-on-store and reset-mid-access scenarios.
module tb_multicycle_sequencer;

    localparam int N_INSTR = 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt_req, mem_ready;
    logic        dec_mem_to_reg, dec_mem_write, dec_branch, dec_reg_write;
    logic        branch_taken;
    logic        ir_we, pc_we, pc_src_branch, reg_we, retire, busy, err;
    logic [2:0]  state_o;
    logic [31:0] instr_count;

    multicycle_sequencer_if mif();
    assign mif.mem_ready = mem_ready;

    multicycle_sequencer #(.MEM_TIMEOUT(4), .TMO_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .dec_mem_to_reg (dec_mem_to_reg),
        .dec_mem_write  (dec_mem_write),
        .dec_branch     (dec_branch),
        .dec_reg_write  (dec_reg_write),
        .branch_taken   (branch_taken),
        .mem            (mif),
        .ir_we          (ir_we),
        .pc_we          (pc_we),
        .pc_src_branch  (pc_src_branch),
        .reg_we         (reg_we),
        .retire         (retire),
        .busy           (busy),
        .err            (err),
        .state_o        (state_o),
        .instr_count    (instr_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] sig;
        logic [2:0]  nxt;
    } exp_t;

    typedef struct packed {
        logic       mtr, mw, br, rw, bt, halt;
        logic [1:0] fw, mwait;
    } instr_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected per-instruction signature from the instruction-class rules:
    // {cycles, ir_we, pc_we, pc_src, reg_we, fetch cycles, mem cycles, store cycles}
    function automatic logic [47:0] model_sig(input instr_t i);
        int base, memc, stc, regw, pcw, brp, cyc;
        memc = 0; stc = 0; regw = 0; pcw = 1; brp = 0;
        if (i.br)       begin base = 3; pcw = 1 + int'(i.bt); brp = 1; end
        else if (i.mw)  begin base = 4; memc = 1 + int'(i.mwait); stc = memc; end
        else if (i.mtr) begin base = 5; memc = 1 + int'(i.mwait); regw = 1; end
        else if (i.rw)  begin base = 4; regw = 1; end
        else            base = 3;
        cyc = base + int'(i.fw) + ((memc != 0) ? int'(i.mwait) : 0);
        return {8'(cyc), 4'd1, 4'(pcw), 4'(brp), 4'(regw),
                8'(1 + int'(i.fw)), 8'(memc), 8'(stc)};
    endfunction

    task automatic set_dec(input logic [3:0] d);
        {dec_mem_to_reg, dec_mem_write, dec_branch, dec_reg_write} = d;
    endtask

    initial begin
        instr_t cur;
        int     issued, fetch_left, mem_left, idle_left, n, cyc;
        logic   need_new;
        exp_t   e;

        rst_n = 1'b0; start = 1'b1; halt_req = 1'b0; mem_ready = 1'b1;
        set_dec(4'hF); branch_taken = 1'b1;
        cur = '0;

        // Monitor: accumulate per-instruction activity, compare at retire.
        fork
            begin
                int   a_cyc, a_ir, a_pc, a_br, a_rw, a_f, a_m, a_s;
                logic chk_next;
                logic [2:0] exp_next;
                exp_t x;
                chk_next = 1'b0; exp_next = '0;
                a_cyc = 0; a_ir = 0; a_pc = 0; a_br = 0; a_rw = 0; a_f = 0; a_m = 0; a_s = 0;
                forever begin
                    @(negedge clk);
                    if (!mon_en || !rst_n) begin
                        a_cyc = 0; a_ir = 0; a_pc = 0; a_br = 0; a_rw = 0; a_f = 0; a_m = 0; a_s = 0;
                        chk_next = 1'b0;
                    end else begin
                        if (chk_next) begin
                            chk("next_state", 64'(state_o), 64'(exp_next));
                            chk_next = 1'b0;
                        end
                        if (busy) begin
                            a_cyc++;
                            if (ir_we) a_ir++;
                            if (pc_we) a_pc++;
                            if (pc_src_branch) a_br++;
                            if (reg_we) a_rw++;
                            if (mif.mem_req && !mif.addr_sel) a_f++;
                            if (mif.mem_req && mif.addr_sel) a_m++;
                            if (mif.mem_req && mif.addr_sel && mif.mem_we) a_s++;
                        end
                        if (retire) begin
                            if (sb.size() == 0) begin
                                total++;
                                $display("FAIL sb_pop: retire with no expected instruction");
                            end else begin
                                x = sb.pop_front();
                                chk("instr_sig",
                                    64'({8'(a_cyc), 4'(a_ir), 4'(a_pc), 4'(a_br), 4'(a_rw),
                                         8'(a_f), 8'(a_m), 8'(a_s)}),
                                    64'(x.sig));
                                chk_next = 1'b1;
                                exp_next = x.nxt;
                            end
                            a_cyc = 0; a_ir = 0; a_pc = 0; a_br = 0; a_rw = 0; a_f = 0; a_m = 0; a_s = 0;
                        end
                    end
                end
            end
        join_none

        // Reset state with active inputs.
        @(posedge clk); #1;
        chk("reset_outputs",
            64'({state_o, mif.mem_req, mif.mem_we, mif.addr_sel, ir_we, pc_we,
                 pc_src_branch, reg_we, retire, busy, err, instr_count}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        mon_en = 1'b1;

        // Randomized instruction stream.
        issued = 0; need_new = 1'b1; fetch_left = 0; mem_left = 0; idle_left = 0;
        cyc = 0;
        while (cyc < 6000 && !(issued == N_INSTR && state_o == 3'd0 && sb.size() == 0)) begin
            @(posedge clk); #1;
            cyc++;
            mem_ready    = 1'($urandom);
            start        = 1'($urandom);
            branch_taken = 1'($urandom);
            set_dec(4'($urandom));
            case (state_o)
                3'd0: begin
                    start = 1'b0;
                    if (issued < N_INSTR) begin
                        if (idle_left == 0) begin
                            start = 1'b1;
                            idle_left = int'($urandom_range(0, 2));
                        end else begin
                            idle_left--;
                        end
                    end
                end
                3'd1: begin
                    if (need_new) begin
                        cur = instr_t'($urandom);
                        cur.fw    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
                        cur.mwait = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
                        cur.halt  = (issued == N_INSTR - 1) || ($urandom_range(0, 5) == 0);
                        fetch_left = int'(cur.fw);
                        need_new = 1'b0;
                    end
                    if (fetch_left > 0) begin
                        mem_ready = 1'b0;
                        fetch_left--;
                    end else begin
                        mem_ready = 1'b1;
                        set_dec({cur.mtr, cur.mw, cur.br, cur.rw});
                        e.sig = model_sig(cur);
                        e.nxt = cur.halt ? 3'd0 : 3'd1;
                        sb.push_back(e);
                        issued++;
                        need_new = 1'b1;
                        mem_left = int'(cur.mwait);
                    end
                end
                3'd2: set_dec({cur.mtr, cur.mw, cur.br, cur.rw});
                3'd3: branch_taken = cur.bt;
                3'd4: begin
                    if (mem_left > 0) begin
                        mem_ready = 1'b0;
                        mem_left--;
                    end else begin
                        mem_ready = 1'b1;
                    end
                end
                default: ;
            endcase
            halt_req = cur.halt;
        end
        @(negedge clk); #1;
        mon_en = 1'b0;
        chk("random_drain", 64'({issued == N_INSTR, sb.size() == 0, state_o}), 64'({2'b11, 3'd0}));
`ifdef PERF_CNT_EN
        chk("instr_count", 64'(instr_count), 64'(N_INSTR));
`else
        chk("instr_count", 64'(instr_count), 64'd0);
`endif

        // Fetch timeout into ERR; start ignored afterwards.
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; halt_req = 1'b0; set_dec(4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (state_o == 3'd1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("tmo_fetch_cycles", 64'(n), 64'd4);
        chk("tmo_err_outputs",
            64'({state_o, err, busy, mif.mem_req, ir_we, pc_we, reg_we, retire, pc_src_branch}),
            64'({3'd6, 8'b1000_0000}));
        repeat (5) begin
            start = 1'b1; mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk("err_sticky", 64'({state_o, err, busy}), 64'({3'd6, 1'b1, 1'b0}));

        // Store held in MEM, then retired with halt_req.
        rst_n = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b1; mem_ready = 1'b1; set_dec(4'b0100);
        @(posedge clk); #1;                 // FETCH, accepted this cycle
        start = 1'b0;
        @(posedge clk); #1;                 // DECODE
        @(posedge clk); #1;                 // EXEC
        mem_ready = 1'b0; set_dec(4'b1011);
        @(posedge clk); #1;                 // MEM
        chk("store_mem_hold1", 64'({state_o, mif.mem_req, mif.addr_sel, mif.mem_we}), 64'({3'd4, 3'b111}));
        @(posedge clk); #1;
        chk("store_mem_hold2", 64'({state_o, mif.mem_req, mif.addr_sel, mif.mem_we}), 64'({3'd4, 3'b111}));
        halt_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("store_retire", 64'({retire, reg_we}), 64'({1'b1, 1'b0}));
        @(posedge clk); #1;
        chk("halt_to_idle", 64'({state_o, busy, mif.mem_req}), 64'd0);

        // Reset asserted in the middle of a load's MEM phase.
        halt_req = 1'b0; start = 1'b1; mem_ready = 1'b1; set_dec(4'b1000);
        @(posedge clk); #1;                 // FETCH
        start = 1'b0;
        @(posedge clk); #1;                 // DECODE
        @(posedge clk); #1;                 // EXEC
        mem_ready = 1'b0;
        @(posedge clk); #1;                 // MEM
        chk("load_mem_req", 64'({state_o, mif.mem_req, mif.addr_sel, mif.mem_we}), 64'({3'd4, 3'b110}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_mem",
            64'({state_o, mif.mem_req, mif.addr_sel, retire, busy, reg_we, instr_count}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
